// File: rtl/embedded_dpram.sv
// embedded_dpram: dual-port Avalon-MM RAM with byte enables, selectable
// read latency, clear-on-reset sequencer and fixed collision priority.
module embedded_dpram #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 15,
    parameter int DEPTH          = 25000,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clken,
    input  logic                    reset_req,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    output logic                    s1_waitrequest,
    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,
    output logic                    s2_waitrequest,
    output logic                    busy
);
    localparam int BE = DATA_WIDTH / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_V = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t state;
    logic [IW-1:0] clr_addr;
    logic en;
    logic stall;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] addr [2];
    logic [IW-1:0] idx [2];
    logic [BE-1:0] be [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    logic [1:0] cs, rd, wr;
    logic [1:0] inr, wr_acc, rd_acc;

    logic [1:0] v1, vq;
    logic [DATA_WIDTH-1:0] d1 [2];
    logic [DATA_WIDTH-1:0] dq [2];

    assign en = clken & ~reset_req;
    assign stall = ~en | busy;
    assign s1_waitrequest = stall;
    assign s2_waitrequest = stall;

    assign addr[0]  = s1_address;
    assign addr[1]  = s2_address;
    assign be[0]    = s1_byteenable;
    assign be[1]    = s2_byteenable;
    assign wdata[0] = s1_writedata;
    assign wdata[1] = s2_writedata;
    assign cs = {s2_chipselect, s1_chipselect};
    assign rd = {s2_read, s1_read};
    assign wr = {s2_write, s1_write};

    // Read with write in the same cycle is a write only.
    always_comb begin
        inr    = '0;
        wr_acc = '0;
        rd_acc = '0;
        for (int p = 0; p < 2; p++) begin
            idx[p]    = addr[p][IW-1:0];
            inr[p]    = {1'b0, addr[p]} < DEPTH_V;
            wr_acc[p] = ~reset & ~stall & cs[p] & wr[p];
            rd_acc[p] = ~reset & ~stall & cs[p] & rd[p] & ~wr[p];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            busy     <= (CLEAR_ON_RESET != 0);
            clr_addr <= '0;
        end else if (en && state == CLEAR) begin
            clr_addr <= clr_addr + IW'(1);
            if (clr_addr == LAST) begin
                state <= READY;
                busy  <= 1'b0;
            end
        end
    end

    // s2 is applied first so s1 overrides it on shared lanes.
    always_ff @(posedge clk) begin
        if (!reset && en && state == CLEAR)
            mem[clr_addr] <= '0;
        for (int p = 1; p >= 0; p--) begin
            if (wr_acc[p] && inr[p]) begin
                for (int i = 0; i < BE; i++) begin
                    if (be[p][i])
                        mem[idx[p]][8*i +: 8] <= wdata[p][8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1    <= '0;
            d1[0] <= '0;
            d1[1] <= '0;
        end else if (en) begin
            v1 <= rd_acc;
            for (int p = 0; p < 2; p++) begin
                if (rd_acc[p])
                    d1[p] <= inr[p] ? mem[idx[p]] : '0;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [1:0] v2;
            logic [DATA_WIDTH-1:0] d2 [2];

            always_ff @(posedge clk) begin
                if (reset) begin
                    v2    <= '0;
                    d2[0] <= '0;
                    d2[1] <= '0;
                end else if (en) begin
                    v2 <= v1;
                    for (int p = 0; p < 2; p++) begin
                        if (v1[p])
                            d2[p] <= d1[p];
                    end
                end
            end

            assign vq    = v2;
            assign dq[0] = d2[0];
            assign dq[1] = d2[1];
        end else begin : g_lat1
            assign vq    = v1;
            assign dq[0] = d1[0];
            assign dq[1] = d1[1];
        end
    endgenerate

    assign s1_readdata      = dq[0];
    assign s2_readdata      = dq[1];
    assign s1_readdatavalid = vq[0] & en;
    assign s2_readdatavalid = vq[1] & en;
endmodule

// File: tb/tb_embedded_dpram.sv
// tb_embedded_dpram: drives latency-1 and latency-2 instances with shared
// stimulus and compares both against a cycle-level reference model.
module tb_embedded_dpram;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, clken, reset_req;
    logic [AW-1:0] a1, a2;
    logic cs1, cs2, rd1, rd2, wr1, wr2;
    logic [3:0] be1, be2;
    logic [DW-1:0] wd1, wd2;

    // index = instance*2 + port; instance 0 is latency 1, 1 is latency 2
    logic [DW-1:0] rdat [4];
    logic rvld [4];
    logic wreq [4];
    logic busy_o [2];

    int checks = 0;
    int errors = 0;

    embedded_dpram #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .READ_LATENCY(1), .CLEAR_ON_RESET(1)
    ) u_dut (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .s1_address(a1), .s1_chipselect(cs1), .s1_read(rd1),
        .s1_write(wr1), .s1_byteenable(be1), .s1_writedata(wd1),
        .s1_readdata(rdat[0]), .s1_readdatavalid(rvld[0]),
        .s1_waitrequest(wreq[0]),
        .s2_address(a2), .s2_chipselect(cs2), .s2_read(rd2),
        .s2_write(wr2), .s2_byteenable(be2), .s2_writedata(wd2),
        .s2_readdata(rdat[1]), .s2_readdatavalid(rvld[1]),
        .s2_waitrequest(wreq[1]),
        .busy(busy_o[0])
    );

    embedded_dpram #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .READ_LATENCY(2), .CLEAR_ON_RESET(1)
    ) u_dut2 (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .s1_address(a1), .s1_chipselect(cs1), .s1_read(rd1),
        .s1_write(wr1), .s1_byteenable(be1), .s1_writedata(wd1),
        .s1_readdata(rdat[2]), .s1_readdatavalid(rvld[2]),
        .s1_waitrequest(wreq[2]),
        .s2_address(a2), .s2_chipselect(cs2), .s2_read(rd2),
        .s2_write(wr2), .s2_byteenable(be2), .s2_writedata(wd2),
        .s2_readdata(rdat[3]), .s2_readdatavalid(rvld[3]),
        .s2_waitrequest(wreq[3]),
        .busy(busy_o[1])
    );

    // reference model: memory words, words left to clear, pending responses
    typedef struct {
        int due;
        logic [DW-1:0] data;
    } rsp_t;

    logic [DW-1:0] mm [DEPTH];
    int clear_left;
    int ecnt;
    rsp_t rq [4][$];
    logic [DW-1:0] shown [4];

    task automatic check(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        ecnt = 0;
        clear_left = DEPTH;
        for (int k = 0; k < 4; k++) begin
            rq[k].delete();
            shown[k] = '0;
        end
    endtask

    task automatic model_edge();
        int ad [2];
        logic acc [2];
        logic isw [2];
        logic [3:0] bb [2];
        logic [DW-1:0] wv [2];
        logic [DW-1:0] dv;
        rsp_t r;
        if (reset) begin
            model_reset();
            return;
        end
        if (!(clken && !reset_req))
            return;
        ad[0] = int'(a1);
        ad[1] = int'(a2);
        acc[0] = cs1 && (rd1 || wr1);
        acc[1] = cs2 && (rd2 || wr2);
        isw[0] = wr1;
        isw[1] = wr2;
        bb[0] = be1;
        bb[1] = be2;
        wv[0] = wd1;
        wv[1] = wd2;
        ecnt++;
        for (int k = 0; k < 4; k++) begin
            while (rq[k].size() > 0 && rq[k][0].due < ecnt)
                void'(rq[k].pop_front());
        end
        if (clear_left > 0) begin
            mm[DEPTH - clear_left] = '0;
            clear_left--;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (acc[p] && !isw[p]) begin
                    dv = (ad[p] < DEPTH) ? mm[ad[p]] : '0;
                    for (int i = 0; i < 2; i++) begin
                        r.due = ecnt + i;
                        r.data = dv;
                        rq[i*2 + p].push_back(r);
                    end
                end
            end
            // reads above saw old data; s1 lanes take priority over s2
            for (int p = 1; p >= 0; p--) begin
                if (acc[p] && isw[p] && ad[p] < DEPTH) begin
                    for (int l = 0; l < 4; l++) begin
                        if (bb[p][l])
                            mm[ad[p]][8*l +: 8] = wv[p][8*l +: 8];
                    end
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (rq[k].size() > 0 && rq[k][0].due == ecnt)
                shown[k] = rq[k][0].data;
        end
    endtask

    task automatic model_check();
        logic en;
        logic bexp;
        logic vexp;
        en = clken && !reset_req;
        bexp = (clear_left > 0);
        for (int i = 0; i < 2; i++)
            check($sformatf("busy_i%0d", i), 32'(busy_o[i]), 32'(bexp));
        for (int k = 0; k < 4; k++) begin
            vexp = en && rq[k].size() > 0 && rq[k][0].due == ecnt;
            check($sformatf("wreq_k%0d", k), 32'(wreq[k]), 32'(!en || bexp));
            check($sformatf("rvld_k%0d", k), 32'(rvld[k]), 32'(vexp));
            check($sformatf("rdat_k%0d", k), rdat[k], shown[k]);
        end
    endtask

    task automatic tick();
        #1;
        model_check();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        clken = 1'b1;
        reset_req = 1'b0;
        cs1 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
        cs2 = 1'b0; rd2 = 1'b0; wr2 = 1'b0;
        a1 = '0; a2 = '0;
        be1 = '0; be2 = '0;
        wd1 = '0; wd2 = '0;
    endtask

    task automatic s1_wr(int ad, logic [DW-1:0] d, logic [3:0] b);
        cs1 = 1'b1; wr1 = 1'b1; rd1 = 1'b0;
        a1 = AW'(ad); wd1 = d; be1 = b;
    endtask

    task automatic s1_rd(int ad);
        cs1 = 1'b1; rd1 = 1'b1; wr1 = 1'b0; a1 = AW'(ad);
    endtask

    task automatic s2_rd(int ad);
        cs2 = 1'b1; rd2 = 1'b1; wr2 = 1'b0; a2 = AW'(ad);
    endtask

    // bounded wait for a response on output k, then compare its data
    task automatic expect_rd(int k, logic [DW-1:0] exp, string tag);
        int n = 0;
        while (rvld[k] !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_vld"}, 32'(rvld[k]), 32'd1);
        check(tag, rdat[k], exp);
    endtask

    task automatic count_busy(string tag);
        int n = 0;
        while (busy_o[0] === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'd16);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        tick();
        reset = 1'b0;
        count_busy("clear_cycles");

        s1_rd(5);
        tick();
        idle();
        check("clr_rd5_vld", 32'(rvld[0]), 32'd1);
        check("clr_rd5_dat", rdat[0], 32'h0);
        tick();

        s1_wr(3, 32'hAABBCCDD, 4'hF);
        tick();
        s1_wr(3, 32'h11223344, 4'h5);
        tick();
        idle();
        s2_rd(3);
        tick();
        idle();
        expect_rd(1, 32'hAA22CC44, "lane_rd3");

        s1_wr(9, 32'h11111111, 4'h3);
        cs2 = 1'b1; wr2 = 1'b1; a2 = AW'(9);
        wd2 = 32'h22222222; be2 = 4'hF;
        tick();
        idle();
        s1_rd(9);
        tick();
        idle();
        expect_rd(0, 32'h22221111, "coll_ww");

        s1_wr(7, 32'hCAFEF00D, 4'hF);
        tick();
        s1_wr(7, 32'h12345678, 4'hF);
        s2_rd(7);
        tick();
        idle();
        expect_rd(1, 32'hCAFEF00D, "coll_rw_old");
        s2_rd(7);
        tick();
        idle();
        expect_rd(1, 32'h12345678, "coll_rw_new");
        tick();
        tick();

        for (int i = 0; i < 4; i++) begin
            s1_wr(i, DW'(i), 4'hF);
            tick();
        end
        idle();
        tick();
        for (int s = 0; s < 7; s++) begin
            idle();
            if (s < 4)
                s1_rd(s);
            tick();
            check($sformatf("stream_vld_s%0d", s), 32'(rvld[2]),
                  32'(s >= 1 && s <= 4));
            if (s >= 1 && s <= 4)
                check($sformatf("stream_dat_s%0d", s), rdat[2], DW'(s - 1));
        end

        s1_wr(20, 32'hDEADBEEF, 4'hF);
        tick();
        idle();
        s1_rd(20);
        tick();
        idle();
        expect_rd(0, 32'h0, "oor_rd20");
        s1_rd(4);
        tick();
        idle();
        expect_rd(0, 32'h0, "oor_alias4");

        s1_rd(2);
        tick();
        idle();
        clken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_wreq1", 32'(wreq[0]), 32'd1);
            check("stall_wreq2", 32'(wreq[1]), 32'd1);
            check("stall_vld", 32'(rvld[0]), 32'd0);
        end
        clken = 1'b1;
        #1;
        check("stall_resume_vld", 32'(rvld[0]), 32'd1);
        check("stall_resume_dat", rdat[0], 32'd2);
        tick();
        tick();
        tick();

        for (int c = 0; c < 500; c++) begin
            clken = ($urandom_range(0, 9) != 0);
            reset_req = ($urandom_range(0, 19) == 0);
            a1 = AW'($urandom_range(0, 19));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : AW'($urandom_range(0, 19));
            cs1 = ($urandom_range(0, 4) != 0);
            cs2 = ($urandom_range(0, 4) != 0);
            rd1 = 1'($urandom_range(0, 1));
            rd2 = 1'($urandom_range(0, 1));
            wr1 = ($urandom_range(0, 2) == 0);
            wr2 = ($urandom_range(0, 2) == 0);
            be1 = 4'($urandom);
            be2 = 4'($urandom);
            wd1 = $urandom;
            wd2 = $urandom;
            tick();
        end
        idle();
        tick();
        tick();

        s1_wr(12, 32'h00005555, 4'hF);
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++)
            tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_busy("midclear_cycles");
        s1_rd(12);
        tick();
        idle();
        expect_rd(0, 32'h0, "midclear_rd12");
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
